// File: rtl/kyber_bus_master.sv
// Bus initiator for the Kyber 32-bit accelerator bus: runs queued WRITE/READ/POLL commands.
// Optional REQ timeout/abort is built only when KYBER_BUS_TIMEOUT_EN is defined.
module kyber_bus_master #(
  parameter int unsigned LEN_W          = 8,
  parameter int unsigned POLL_MAX       = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_mask,
  input  logic [31:0]      cmd_cmp,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             done,
  output logic             done_err,
  output logic             busy,
  output logic             bus_enable,
  output logic             bus_write,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_ready
);
  localparam int unsigned PollW = $clog2(POLL_MAX + 1);
  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpPoll  = 2'b10;

  typedef enum logic [2:0] {StIdle, StWdat, StReq, StRsp, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d, mask_q, mask_d, cmp_q, cmp_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic             err_q, err_d;
  logic             cmd_ready_q, cmd_ready_d, wr_ready_q, wr_ready_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             done_q, done_d, done_err_q, done_err_d, busy_q, busy_d;
  logic             bus_enable_q, bus_enable_d, bus_write_q, bus_write_d;
  logic [31:0]      bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic             match, timeout;

`ifdef KYBER_BUS_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  // Counts unacknowledged REQ cycles of the current beat only.
  assign to_cnt_d = (state_q == StReq && !bus_ready) ? to_cnt_q + ToW'(1) : '0;
  assign timeout  = (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  assign match = ((bus_rdata & mask_q) == (cmp_q & mask_q));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    cmp_d       = cmp_q;
    len_d       = len_q;
    beat_d      = beat_q;
    poll_d      = poll_q;
    err_d       = err_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = (cmd_op == 2'b11) ? OpRead : cmd_op;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          mask_d  = cmd_mask;
          cmp_d   = cmd_cmp;
          beat_d  = '0;
          poll_d  = '0;
          err_d   = 1'b0;
          state_d = (cmd_op == OpWrite) ? StWdat : StReq;
        end
      end
      StWdat: begin
        if (wr_valid) begin
          bus_wdata_d = wr_data;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (bus_ready) begin
          if (op_q == OpWrite) begin
            state_d = StGap;
          end else if (op_q == OpRead || match) begin
            rsp_data_d = bus_rdata;
            rsp_err_d  = 1'b0;
            state_d    = StRsp;
          end else if (poll_q == PollW'(POLL_MAX - 1)) begin
            rsp_data_d = bus_rdata;
            rsp_err_d  = 1'b1;
            err_d      = 1'b1;
            state_d    = StRsp;
          end else begin
            poll_d  = poll_q + PollW'(1);
            state_d = StGap;
          end
        end else if (timeout) begin
          err_d = 1'b1;
          if (op_q == OpWrite) begin
            state_d = StDone;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = StRsp;
          end
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          if (op_q == OpRead && !err_q && beat_q < len_q) begin
            beat_d  = beat_q + LEN_W'(1);
            state_d = StReq;
          end else begin
            state_d = StDone;
          end
        end
      end
      StGap: begin
        if (op_q == OpPoll) begin
          state_d = StReq;
        end else if (beat_q < len_q) begin
          beat_d  = beat_q + LEN_W'(1);
          state_d = StWdat;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered: decode them from the state being entered.
    cmd_ready_d  = (state_d == StIdle);
    wr_ready_d   = (state_d == StWdat);
    rsp_valid_d  = (state_d == StRsp);
    done_d       = (state_d == StDone);
    done_err_d   = (state_d == StDone) && err_d;
    busy_d       = (state_d != StIdle);
    bus_enable_d = (state_d == StReq);
    bus_write_d  = (state_d == StReq) && (op_d == OpWrite);
    bus_addr_d   = (state_d == StReq) ? addr_d + (32'(beat_d) << 2) : bus_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= OpWrite;
      addr_q       <= '0;
      mask_q       <= '0;
      cmp_q        <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      poll_q       <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      wr_ready_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      bus_enable_q <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
`ifdef KYBER_BUS_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      cmp_q        <= cmp_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      poll_q       <= poll_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      wr_ready_q   <= wr_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
      busy_q       <= busy_d;
      bus_enable_q <= bus_enable_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
`ifdef KYBER_BUS_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wr_ready   = wr_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign done       = done_q;
  assign done_err   = done_err_q;
  assign busy       = busy_q;
  assign bus_enable = bus_enable_q;
  assign bus_write  = bus_write_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_kyber_bus_master.sv
// Self-checking bench for kyber_bus_master: vector table, random commands, timing/reset corners.
module tb_kyber_bus_master;
  localparam int unsigned LenW     = 8;
  localparam int unsigned PollMax  = 8;
  localparam int unsigned ToCycles = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [31:0]     cmd_addr = '0, cmd_mask = '0, cmd_cmp = '0;
  logic [LenW-1:0] cmd_len = '0;
  logic            wr_valid, wr_ready;
  logic [31:0]     wr_data;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [31:0]     rsp_data;
  logic            done, done_err, busy;
  logic            bus_enable, bus_write, bus_ready;
  logic [31:0]     bus_addr, bus_wdata, bus_rdata;

  kyber_bus_master #(
    .LEN_W(LenW), .POLL_MAX(PollMax), .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_mask(cmd_mask), .cmd_cmp(cmd_cmp),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .done(done), .done_err(done_err), .busy(busy),
    .bus_enable(bus_enable), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  // Slave model state
  logic [31:0] rd_xor = '0;
  logic [31:0] busy_val = 32'h0000_0002;
  int busy_left = 0, lat = 1, wait_cnt = 0;
  bit never_ack = 1'b0;
  int gap_viol = 0, overlap = 0, en_cycles = 0, first_en_cyc = -1, ack_cyc = -1;
  logic [31:0] wr_addr_log[$], wr_data_log[$], rd_addr_log[$];
  // Response / completion monitor state
  logic [31:0] rsp_data_log[$];
  logic        rsp_err_log[$];
  bit rsp_rand = 1'b0;
  int stall_beat = 0, stall_left = 0, first_rsp_cyc = -1;
  int done_cnt = 0, done_cyc = -1;
  logic last_done_err = 1'b0;
  // Write stream source
  logic [31:0] wr_q[$], exp_wdata[$];
  bit wr_hs = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          len;
    logic [31:0] mask;
    logic [31:0] cmp;
    logic [31:0] rd_xor;
    int          busy;
    int          exp_reads;
    logic [31:0] poll_data;
    logic        exp_err;
  } vec_t;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Bus slave: acks after `lat` extra cycles, reads return busy_val then rd_xor^addr.
  initial begin
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_enable) begin
        en_cycles++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (bus_ready) gap_viol++;
      end
      if (bus_enable && !bus_ready && !never_ack) begin
        if (wait_cnt >= lat) begin
          bus_ready = 1'b1;
          wait_cnt  = 0;
          if (ack_cyc < 0) ack_cyc = cyc;
          if (bus_write) begin
            wr_addr_log.push_back(bus_addr);
            wr_data_log.push_back(bus_wdata);
          end else begin
            rd_addr_log.push_back(bus_addr);
            if (busy_left > 0) begin
              bus_rdata = busy_val;
              busy_left--;
            end else begin
              bus_rdata = rd_xor ^ bus_addr;
            end
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        bus_ready = 1'b0;
        wait_cnt  = 0;
        bus_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rsp_valid && bus_enable) overlap++;
      if (rsp_valid && rsp_data_log.size() == stall_beat && stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
      end else if (rsp_rand) begin
        rsp_ready = ($urandom_range(0, 1) == 1);
      end else begin
        rsp_ready = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_data_log.push_back(rsp_data);
        rsp_err_log.push_back(rsp_err);
        if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        last_done_err = done_err;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  end

  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge clk);
      if (wr_hs && wr_q.size() > 0) void'(wr_q.pop_front());
      wr_valid = (wr_q.size() > 0);
      wr_data  = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
      wr_hs    = wr_valid && wr_ready;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic prep(input logic [31:0] x, input int busy_n, input int l);
    rd_xor = x; busy_left = busy_n; lat = l; never_ack = 1'b0;
    wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
    rsp_data_log.delete(); rsp_err_log.delete(); exp_wdata.delete();
    done_cnt = 0; done_cyc = -1; first_en_cyc = -1; ack_cyc = -1; first_rsp_cyc = -1;
    gap_viol = 0; overlap = 0; en_cycles = 0; stall_left = 0; stall_beat = 0; rsp_rand = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input int len,
                          input logic [31:0] mask, input logic [31:0] cmp, output int c0);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = LenW'(len);
    cmd_mask = mask; cmd_cmp = cmp;
    c0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  // Expected outcome from the command rules: beat addresses, data streams, poll result.
  task automatic check_cmd(input string tag, input logic [1:0] op, input logic [31:0] addr,
                           input int len, input int exp_reads, input logic [31:0] poll_data,
                           input logic exp_err);
    int bad;
    logic [31:0] a;
    bad = 0;
    check({tag, " done count"}, 32'(done_cnt), 32'd1);
    check({tag, " done_err"}, 32'(last_done_err), 32'(exp_err));
    check({tag, " enable during rsp"}, 32'(overlap), 32'd0);
    check({tag, " back-to-back enable"}, 32'(gap_viol), 32'd0);
    if (op == 2'b00) begin
      check({tag, " write beats"}, 32'(wr_addr_log.size()), 32'(len + 1));
      check({tag, " read beats"}, 32'(rd_addr_log.size()), 32'd0);
      for (int i = 0; i < wr_addr_log.size(); i++) begin
        a = addr + 32'(4 * i);
        if (i >= exp_wdata.size() || wr_addr_log[i] !== a || wr_data_log[i] !== exp_wdata[i])
          bad++;
      end
      check({tag, " write addr/data errors"}, 32'(bad), 32'd0);
      check({tag, " rsp count"}, 32'(rsp_data_log.size()), 32'd0);
    end else if (op == 2'b10) begin
      check({tag, " poll reads"}, 32'(rd_addr_log.size()), 32'(exp_reads));
      for (int i = 0; i < rd_addr_log.size(); i++) if (rd_addr_log[i] !== addr) bad++;
      check({tag, " poll addr errors"}, 32'(bad), 32'd0);
      check({tag, " rsp count"}, 32'(rsp_data_log.size()), 32'd1);
      if (rsp_data_log.size() > 0) begin
        check({tag, " poll rsp_data"}, rsp_data_log[0], poll_data);
        check({tag, " poll rsp_err"}, 32'(rsp_err_log[0]), 32'(exp_err));
      end
    end else begin
      check({tag, " read beats"}, 32'(rd_addr_log.size()), 32'(len + 1));
      check({tag, " write beats"}, 32'(wr_addr_log.size()), 32'd0);
      check({tag, " rsp count"}, 32'(rsp_data_log.size()), 32'(len + 1));
      for (int i = 0; i < rd_addr_log.size(); i++) begin
        a = addr + 32'(4 * i);
        if (rd_addr_log[i] !== a) bad++;
        if (i < rsp_data_log.size() && (rsp_data_log[i] !== (rd_xor ^ a) || rsp_err_log[i] !== 1'b0))
          bad++;
      end
      check({tag, " read addr/data errors"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[9];
    int c0, t, nbeats;
    logic [1:0] op;
    logic [31:0] addr, d;

    vecs[0] = '{op: 2'b00, addr: 32'h1000, len: 255, mask: 0, cmp: 0, rd_xor: 0, busy: 0,
                exp_reads: 0, poll_data: 0, exp_err: 1'b0};
    vecs[1] = '{op: 2'b01, addr: 32'h10, len: 0, mask: 0, cmp: 0, rd_xor: 32'h5, busy: 0,
                exp_reads: 0, poll_data: 0, exp_err: 1'b0};
    vecs[2] = '{op: 2'b01, addr: 32'h1000, len: 3, mask: 0, cmp: 0, rd_xor: 32'hCAFE_0000,
                busy: 0, exp_reads: 0, poll_data: 0, exp_err: 1'b0};
    vecs[3] = '{op: 2'b01, addr: 32'hFFFF_FFF8, len: 3, mask: 0, cmp: 0, rd_xor: 0, busy: 0,
                exp_reads: 0, poll_data: 0, exp_err: 1'b0};
    vecs[4] = '{op: 2'b11, addr: 32'h40, len: 1, mask: 0, cmp: 0, rd_xor: 0, busy: 0,
                exp_reads: 0, poll_data: 0, exp_err: 1'b0};
    vecs[5] = '{op: 2'b10, addr: 32'h0, len: 0, mask: 32'h2, cmp: 32'h0, rd_xor: 32'hFFFF_FFFD,
                busy: 5, exp_reads: 6, poll_data: 32'hFFFF_FFFD, exp_err: 1'b0};
    vecs[6] = '{op: 2'b10, addr: 32'h100, len: 9, mask: 32'h2, cmp: 32'h0, rd_xor: 0,
                busy: 1000, exp_reads: PollMax, poll_data: 32'h2, exp_err: 1'b1};
    vecs[7] = '{op: 2'b10, addr: 32'h104, len: 0, mask: 32'h2, cmp: 32'h0, rd_xor: 0,
                busy: PollMax - 1, exp_reads: PollMax, poll_data: 32'h104, exp_err: 1'b0};
    vecs[8] = '{op: 2'b10, addr: 32'h20, len: 0, mask: 32'hFF, cmp: 32'h5A, rd_xor: 32'h7A,
                busy: 0, exp_reads: 1, poll_data: 32'h5A, exp_err: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset bus_enable", 32'(bus_enable), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset wr_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      prep(vecs[k].rd_xor, vecs[k].busy, 1);
      if (vecs[k].op == 2'b00) begin
        for (int i = 0; i <= vecs[k].len; i++) begin
          exp_wdata.push_back(32'(i));
          wr_q.push_back(32'(i));
        end
      end
      send_cmd(vecs[k].op, vecs[k].addr, vecs[k].len, vecs[k].mask, vecs[k].cmp, c0);
      wait_done(5000);
      check_cmd($sformatf("vec%0d", k), vecs[k].op, vecs[k].addr, vecs[k].len,
                vecs[k].exp_reads, vecs[k].poll_data, vecs[k].exp_err);
    end

    // Random WRITE/READ/reserved commands with random slave latency and rsp backpressure
    for (int n = 0; n < 20; n++) begin
      prep($urandom, 0, $urandom_range(0, 3));
      rsp_rand = 1'b1;
      case ($urandom_range(0, 2))
        0: op = 2'b00;
        1: op = 2'b01;
        default: op = 2'b11;
      endcase
      addr = $urandom & 32'hFFFF_FFFC;
      nbeats = $urandom_range(1, 8);
      if (op == 2'b00) begin
        for (int i = 0; i < nbeats; i++) begin
          d = $urandom;
          exp_wdata.push_back(d);
          wr_q.push_back(d);
        end
      end
      send_cmd(op, addr, nbeats - 1, $urandom, $urandom, c0);
      wait_done(5000);
      check_cmd($sformatf("rand%0d", n), op, addr, nbeats - 1, 0, 32'h0, 1'b0);
    end

    // Minimum single-write latency with write data already waiting
    prep(0, 0, 1);
    wr_q.push_back(32'hA5A5_1234);
    exp_wdata.push_back(32'hA5A5_1234);
    repeat (2) @(negedge clk);
    send_cmd(2'b00, 32'h2000, 0, 0, 0, c0);
    wait_done(100);
    check("wr latency enable", 32'(first_en_cyc - c0), 32'd2);
    check("wr latency ack", 32'(ack_cyc - c0), 32'd3);
    check("wr latency done", 32'(done_cyc - c0), 32'd5);
    check_cmd("single write", 2'b00, 32'h2000, 0, 0, 32'h0, 1'b0);

    // Single-beat read timing
    prep(32'h5, 0, 1);
    send_cmd(2'b01, 32'h10, 0, 0, 0, c0);
    wait_done(100);
    check("rd latency enable", 32'(first_en_cyc - c0), 32'd1);
    check("rd latency ack", 32'(ack_cyc - c0), 32'd2);
    check("rd latency rsp", 32'(first_rsp_cyc - c0), 32'd3);
    check("rd latency done", 32'(done_cyc - c0), 32'd4);
    if (rsp_data_log.size() > 0) check("rd single data", rsp_data_log[0], 32'h15);
    check_cmd("single read", 2'b01, 32'h10, 0, 0, 32'h0, 1'b0);

    // 10-cycle rsp stall on beat 1, plus a command offered while busy
    prep(32'hCAFE_0000, 0, 1);
    stall_beat = 1;
    stall_left = 10;
    send_cmd(2'b01, 32'h1000, 3, 0, 0, c0);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(500);
    check("stall consumed", 32'(stall_left), 32'd0);
    check_cmd("stalled read", 2'b01, 32'h1000, 3, 0, 32'h0, 1'b0);

`ifdef KYBER_BUS_TIMEOUT_EN
    prep(0, 0, 1);
    never_ack = 1'b1;
    send_cmd(2'b01, 32'h80, 2, 0, 0, c0);
    wait_done(500);
    check("to read enable cycles", 32'(en_cycles), 32'(ToCycles));
    check("to read done count", 32'(done_cnt), 32'd1);
    check("to read done_err", 32'(last_done_err), 32'd1);
    check("to read rsp count", 32'(rsp_data_log.size()), 32'd1);
    if (rsp_data_log.size() > 0) begin
      check("to read rsp_data", rsp_data_log[0], 32'h0);
      check("to read rsp_err", 32'(rsp_err_log[0]), 32'd1);
    end
    prep(0, 0, 1);
    never_ack = 1'b1;
    wr_q.push_back(32'h1);
    wr_q.push_back(32'h2);
    send_cmd(2'b00, 32'h90, 1, 0, 0, c0);
    wait_done(500);
    check("to write enable cycles", 32'(en_cycles), 32'(ToCycles));
    check("to write done_err", 32'(last_done_err), 32'd1);
    check("to write rsp count", 32'(rsp_data_log.size()), 32'd0);
    check("to write beats left", 32'(wr_q.size()), 32'd1);
    wr_q.delete();
    repeat (2) @(negedge clk);
`endif

    // Asynchronous reset in the middle of a write burst
    prep(0, 0, 2);
    for (int i = 0; i < 8; i++) wr_q.push_back(32'(i));
    send_cmd(2'b00, 32'h3000, 7, 0, 0, c0);
    t = 0;
    while (!(bus_enable && wr_addr_log.size() >= 2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pre-reset bus_enable", 32'(bus_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-reset bus_enable", 32'(bus_enable), 32'd0);
    check("mid-reset busy", 32'(busy), 32'd0);
    check("mid-reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    wr_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("post-reset bus_enable", 32'(bus_enable), 32'd0);
    prep(32'h1234_0000, 0, 1);
    send_cmd(2'b01, 32'h0, 1, 0, 0, c0);
    wait_done(200);
    check_cmd("after reset", 2'b01, 32'h0, 1, 0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
